// File: rtl/mem_rd_arb.sv
// mem_rd_arb: arbitrates N_REQ read requesters onto one memory read port.
// The winner has the highest effective priority, and ties are broken round-robin.
// Effective priority is boosted to 3 after AGE_MAX consecutive losses.
// Issued requester IDs are queued so that in-order read data can be steered back.
// A drain handshake stops issue until every in-flight read has returned.
module mem_rd_arb #(
  parameter int N_REQ   = 3,
  parameter int AW      = 7,
  parameter int DW      = 32,
  parameter int OUTST   = 4,
  parameter int AGE_MAX = 7
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [N_REQ-1:0]         req_ren,
  input  logic [N_REQ*AW-1:0]      req_raddr,
  input  logic [N_REQ*2-1:0]       req_rpri,
  output logic [N_REQ-1:0]         req_rready,
  output logic [DW-1:0]            req_rdata,
  output logic [N_REQ-1:0]         req_rdata_valid,
  output logic                     mem_ren,
  output logic [AW-1:0]            mem_raddr,
  input  logic                     mem_rready,
  input  logic [DW-1:0]            mem_rdata,
  input  logic                     mem_rdata_valid,
  input  logic                     drain_req,
  output logic                     drain_done,
  output logic [$clog2(OUTST):0]   outst_cnt,
  output logic                     err_unexp
);

  localparam int IW = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int PW = (OUTST > 1) ? $clog2(OUTST) : 1;
  localparam int CW = $clog2(OUTST) + 1;
  localparam int GW = $clog2(AGE_MAX + 1);

  typedef enum logic [1:0] {RUN, DRAIN, HALT} state_t;

  state_t                       state_reg, state_next;
  logic [IW-1:0]                rr_ptr_reg;
  logic [N_REQ-1:0][GW-1:0]     age_reg, age_next;
  logic [N_REQ-1:0][1:0]        eff_pri;

  // In-flight ID FIFO. The head is read combinationally so that the return is steered in the same cycle.
  logic [IW-1:0]                id_mem [OUTST];
  logic [PW-1:0]                wr_ptr_reg, rd_ptr_reg;
  logic [CW-1:0]                cnt_reg, cnt_next;
  logic                         err_reg;

  logic                         win_found;
  logic [IW-1:0]                win_idx;
  logic [1:0]                   win_pri;
  logic [IW:0]                  cand_sum;
  logic [IW-1:0]                cand_idx;
  logic [IW-1:0]                head_id;
  logic                         can_issue, issue, pop;

  // Effective priority: an aged-out requester is promoted to the top level.
  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_pri
    assign eff_pri[gi] = (age_reg[gi] == GW'(AGE_MAX)) ? 2'd3 : req_rpri[gi*2 +: 2];
  end

  // Winner search walks from rr_ptr. A strict '>' keeps the first requester found in a tie.
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    win_pri   = '0;
    cand_sum  = '0;
    cand_idx  = '0;
    for (int k = 0; k < N_REQ; k++) begin
      cand_sum = {1'b0, rr_ptr_reg} + (IW+1)'(k);
      if (cand_sum >= (IW+1)'(N_REQ)) begin
        cand_sum = cand_sum - (IW+1)'(N_REQ);
      end
      cand_idx = cand_sum[IW-1:0];
      if (req_ren[cand_idx] && (!win_found || (eff_pri[cand_idx] > win_pri))) begin
        win_found = 1'b1;
        win_idx   = cand_idx;
        win_pri   = eff_pri[cand_idx];
      end
    end
  end

  // Fullness is judged on the registered count, so a same-cycle pop does not open a slot.
  assign can_issue = (state_reg == RUN) && (cnt_reg < CW'(OUTST));
  assign mem_ren   = !rst && can_issue && (|req_ren);
  assign mem_raddr = req_raddr[win_idx*AW +: AW];
  assign issue     = mem_ren && mem_rready;
  assign head_id   = id_mem[rd_ptr_reg];
  assign pop       = !rst && mem_rdata_valid && (cnt_reg != '0);

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_port
    assign req_rready[gi]      = issue && (win_idx == IW'(gi));
    assign req_rdata_valid[gi] = pop && (head_id == IW'(gi));
    // The winner's age clears on issue. Other active requesters age until saturation.
    // Ages are frozen whenever nothing issues.
    assign age_next[gi] = !issue                                          ? age_reg[gi] :
                          (win_idx == IW'(gi))                            ? '0 :
                          (req_ren[gi] && (age_reg[gi] != GW'(AGE_MAX)))  ? age_reg[gi] + 1'b1 :
                                                                            age_reg[gi];
  end

  assign req_rdata  = mem_rdata;
  assign drain_done = !rst && (state_reg == HALT);
  assign outst_cnt  = cnt_reg;
  assign err_unexp  = err_reg;

  // Occupancy after this cycle's issue and pop. A simultaneous issue and pop cancel out.
  always_comb begin
    cnt_next = cnt_reg;
    case ({issue, pop})
      2'b10:   cnt_next = cnt_reg + 1'b1;
      2'b01:   cnt_next = cnt_reg - 1'b1;
      default: cnt_next = cnt_reg;
    endcase
  end

  // Drain FSM next state. DRAIN waits for the post-pop count to reach zero.
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      RUN:     if (drain_req)          state_next = DRAIN;
      DRAIN:   if (cnt_next == '0)     state_next = HALT;
      HALT:    if (!drain_req)         state_next = RUN;
      default:                         state_next = RUN;
    endcase
  end

  // State register, arbitration state, FIFO pointers and the sticky error flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg  <= RUN;
      rr_ptr_reg <= '0;
      age_reg    <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      cnt_reg    <= '0;
      err_reg    <= 1'b0;
    end else begin
      state_reg <= state_next;
      age_reg   <= age_next;
      cnt_reg   <= cnt_next;
      if (issue) begin
        rr_ptr_reg <= (win_idx == IW'(N_REQ-1)) ? '0 : win_idx + 1'b1;
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      if (mem_rdata_valid && (cnt_reg == '0)) begin
        err_reg <= 1'b1;
      end
    end
  end

  // FIFO storage. The entries hold no reset because the pointers define validity.
  always_ff @(posedge clk) begin
    if (issue) begin
      id_mem[wr_ptr_reg] <= win_idx;
    end
  end

endmodule

// File: doc/mem_rd_arb.md
MEM_RD_ARB -- requirements
Module: mem_rd_arb

Interface
REQ-001 SHALL have parameter N_REQ, default 3, number of read requesters.
REQ-002 SHALL have parameter AW, default 7, data-memory read address width ($clog2(list_depth)+$clog2(list_width)).
REQ-003 SHALL have parameter DW, default 32, read data width.
REQ-004 SHALL have parameter OUTST, default 4, maximum outstanding reads (power of two).
REQ-005 SHALL have parameter AGE_MAX, default 7, consecutive losses before a requester's priority is boosted.
REQ-006 SHALL have port clk, input, 1: the single clock, with all logic on its rising edge.
REQ-007 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-008 SHALL have port req_ren, input, N_REQ: per-requester read request.
REQ-009 SHALL have port req_raddr, input, N_REQ*AW: per-requester address, with requester i at bits [i*AW +: AW].
REQ-010 SHALL have port req_rpri, input, N_REQ*2: per-requester priority, with 3 highest.
REQ-011 SHALL have port req_rready, output, N_REQ: per-requester grant/ready.
REQ-012 SHALL have port req_rdata, output, DW: shared return data, equal to mem_rdata.
REQ-013 SHALL have port req_rdata_valid, output, N_REQ: one-hot return-data valid.
REQ-014 SHALL have ports mem_ren (output, 1), mem_raddr (output, AW), mem_rready (input, 1), mem_rdata (input, DW) and mem_rdata_valid (input, 1) for the memory read port.
REQ-015 SHALL have port drain_req, input, 1: stop issuing and empty in-flight reads.
REQ-016 SHALL have port drain_done, output, 1: drained, nothing outstanding.
REQ-017 SHALL have port outst_cnt, output, $clog2(OUTST)+1: in-flight read count.
REQ-018 SHALL have port err_unexp, output, 1: sticky flag for data returned with nothing outstanding.

Function
REQ-019 SHALL define eff_pri[i] as 3 when age[i]==AGE_MAX and as req_rpri[i] otherwise.
REQ-020 SHALL select as winner the requester with req_ren=1 and the highest eff_pri.
REQ-021 SHALL break eff_pri ties round-robin, starting the search at rr_ptr and wrapping from N_REQ-1 to 0.
REQ-022 SHALL define can_issue = (state==RUN) && (outst_cnt<OUTST).
REQ-023 SHALL drive mem_ren = can_issue && |req_ren, together with mem_raddr = winner address, combinationally in the same cycle.
REQ-024 SHALL drive req_rready[winner] = mem_ren && mem_rready and hold every other req_rready at 0.
REQ-025 SHALL define issue = mem_ren && mem_rready.
REQ-026 SHALL, on issue, push the winner index into the ID FIFO, set rr_ptr to (winner+1) mod N_REQ and clear age[winner].
REQ-027 SHALL, on issue, increment age[j] (saturating at AGE_MAX) for every other requester j with req_ren=1.
REQ-028 SHALL leave all age counters unchanged in cycles without issue.
REQ-029 SHALL return data in order: on mem_rdata_valid with the FIFO non-empty, pop the head and drive req_rdata_valid[head]=1 in the same cycle (combinational).
REQ-030 SHALL, when issue and pop occur in the same cycle, leave outst_cnt unchanged.
REQ-031 SHALL judge full using the pre-pop count, so OUTST outstanding blocks issue even if a pop occurs that cycle.
REQ-032 SHALL, on mem_rdata_valid with the FIFO empty, set err_unexp=1 (sticky until rst), perform no pop and keep req_rdata_valid all zero.
REQ-033 SHALL have state RUN, which moves to DRAIN when drain_req=1.
REQ-034 SHALL have state DRAIN, with no new issues, which moves to HALT when outst_cnt==0 after the current cycle's pop.
REQ-035 SHALL have state HALT, with no issues, which moves to RUN when drain_req=0.
REQ-036 SHALL assert drain_done = (state==HALT).
REQ-037 SHALL, with drain_req=1 and nothing outstanding in RUN, go RUN->DRAIN->HALT, asserting drain_done two cycles after drain_req rises.
REQ-038 SHALL keep returning data and popping in DRAIN and HALT.
REQ-039 SHALL give a requester whose req_ren drops while waiting no grant, and SHALL not reset its age.

Reset
REQ-040 SHALL, on rst=1 at a clock edge, set: state=RUN, rr_ptr=0, all age=0, FIFO empty (outst_cnt=0), err_unexp=0.
REQ-041 SHALL, during reset, hold mem_ren=0, req_rready=0, req_rdata_valid=0 and drain_done=0.
REQ-042 SHALL discard in-flight reads on reset mid-operation; returns after reset set err_unexp.

Verification
REQ-043 SHALL be verified with: req_ren=3'b111, all rpri=0, mem_rready=1 for 6 cycles -> grants 0,1,2,0,1,2 and rdata_valid in the same order.
REQ-044 SHALL be verified with: req0 rpri=2 held continuously, req1 rpri=0 requesting -> req1 granted on the 8th cycle (age reaches 7 after 7 losses), then req0 resumes.
REQ-045 SHALL be verified with: mem_rready=1, no mem_rdata_valid, 4 issues -> outst_cnt=4 and mem_ren=0; one mem_rdata_valid -> outst_cnt=3, and issue resumes in the next cycle.
REQ-046 SHALL be verified with: 2 outstanding, drain_req=1 -> no issue, drain_done=1 one cycle after the second return; drain_req=0 -> RUN next cycle.
REQ-047 SHALL be verified with: mem_rdata_valid=1 with outst_cnt=0 -> err_unexp=1 held until rst and req_rdata_valid=0.
REQ-048 SHALL be verified with: rst asserted with 3 outstanding -> outst_cnt=0, age=0, rr_ptr=0 in the next cycle; the first grant after reset goes to requester 0 on ties.
